exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Forward_MUX1  input  2  Rs operand select: 00 ID/EX value, 01 EX/MEM ALU result, 10 WB data, 11 treated as 00.
REQ-005 Forward_MUX2  input  2  Rt operand select, same encoding as Forward_MUX1.
REQ-006 Rs_data_EXE  input  32  Rs register-file value from ID/EX.
REQ-007 Rt_data_EXE  input  32  Rt register-file value from ID/EX.
REQ-008 Imm_EXE  input  32  sign-extended immediate; bits [10:6] are shamt.
REQ-009 Rt_EXE  input  5  Rt field.
REQ-010 Rd_EXE  input  5  Rd field.
REQ-011 ALUSrc_EXE  input  1  1 = operand B is Imm_EXE.
REQ-012 RegDst_EXE  input  1  1 = destination is Rd_EXE, else Rt_EXE.
REQ-013 ALUOp_EXE  input  4  operation code per REQ-027.
REQ-014 Ctrl_EXE  input  4  {RegWrite, MemRead, MemWrite, MemtoReg}.
REQ-015 Valid_EXE  input  1  ID/EX holds a real instruction.
REQ-016 Flush_EXE  input  1  kill the instruction in EX this cycle.
REQ-017 WB_data  input  32  value written back this cycle (forward source 10).
REQ-018 ALU_result_MEM  output  32  registered EX/MEM ALU result; also internal forward source 01.
REQ-019 Store_data_MEM  output  32  registered forwarded Rt value.
REQ-020 RegWr_MEM  output  5  registered destination register.
REQ-021 Ctrl_MEM  output  4  registered control bits.
REQ-022 Valid_MEM  output  1  registered valid.
REQ-023 Busy  output  1  combinational stall request to IF/ID/EX while a multiply is in progress.

Function
REQ-024 Operand A = forwarded Rs; operand B = Imm_EXE if ALUSrc_EXE, else forwarded Rt.
REQ-025 Store_data_MEM captures forwarded Rt regardless of ALUSrc_EXE.
REQ-026 Destination = RegDst_EXE ? Rd_EXE : Rt_EXE.
REQ-027 ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, A SRA (shift forwarded Rt by Imm[10:6]), B LUI (Imm[15:0]<<16), C MULT, D MULTU, E MFHI, F MFLO.
REQ-028 ADD/SUB wrap modulo 2^32; no overflow trap.
REQ-029 Non-multiply valid instruction: EX/MEM registers load at the next edge (1-cycle latency); Busy=0.
REQ-030 Multiplier FSM states IDLE, MUL, DONE; IDLE->MUL when Valid_EXE & ALUOp in {C,D} & !Flush_EXE, latching operands A,B.
REQ-031 MUL: one shift-add iteration per cycle, 32 iterations, then DONE; MULT applies sign correction for a signed 64-bit product.
REQ-032 DONE: HI/LO load product[63:32]/[31:0]; multiply passes to EX/MEM with Valid_MEM=1, Ctrl_MEM RegWrite bit forced 0; FSM->IDLE.
REQ-033 Busy=1 in the IDLE accept cycle and all MUL cycles, 0 in DONE; a multiply thus occupies EX 34 cycles.
REQ-034 While Busy=1, EX/MEM loads a bubble (Valid_MEM=0, Ctrl_MEM=0, RegWr_MEM=0).
REQ-035 Invalid instruction or Flush_EXE: EX/MEM loads a bubble; Flush_EXE has priority over everything except Reset.
REQ-036 Flush_EXE in MUL or DONE: FSM->IDLE, HI/LO unchanged, Busy=0 that cycle.
REQ-037 MFHI/MFLO immediately after a completed multiply reads the new HI/LO.

Reset
REQ-038 Reset: ALU_result_MEM, Store_data_MEM, RegWr_MEM, Ctrl_MEM, Valid_MEM, HI, LO = 0; FSM=IDLE; Busy=0.
REQ-039 Reset mid-multiply aborts it with no HI/LO update.

Structure
REQ-040 Shared package pipeline_pkg holds ALUOp codes, Ctrl_EXE bit indices, forward-select codes, and FSM state encoding.
REQ-041 Iterative multiplier is sub-module mult_iter (start, signed, a, b -> done, product); ALU and EX/MEM register stay in exe_stage.

Verification
REQ-042 ADD, Rs_data=5, Rt_data=7, selects 00 -> ALU_result_MEM=12 one edge later, Valid_MEM=1.
REQ-043 Back-to-back ADD then SUB with Forward_MUX1=01, Rt_data=2 -> SUB result = 12-2 = 10.
REQ-044 Forward_MUX2=10, WB_data=0xFFFF0000, ALUOp AND, Rs_data=0x12345678 -> result 0x12340000.
REQ-045 MULT A=-3, B=4 -> Busy high 33 cycles, bubbles in EX/MEM, then HI=0xFFFFFFFF, LO=0xFFFFFFF4; following MFLO returns 0xFFFFFFF4.
REQ-046 MULTU 0xFFFFFFFF x 2 with Flush_EXE at MUL cycle 10 -> FSM IDLE, HI/LO unchanged, Valid_MEM=0.
REQ-047 Reset asserted during MUL -> all outputs 0 next edge, Busy=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op codes, control bit positions,
// forwarding selects and multiplier FSM encoding.
package pipeline_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOR   = 4'h5,
    OP_SLT   = 4'h6,
    OP_SLTU  = 4'h7,
    OP_SLL   = 4'h8,
    OP_SRL   = 4'h9,
    OP_SRA   = 4'hA,
    OP_LUI   = 4'hB,
    OP_MULT  = 4'hC,
    OP_MULTU = 4'hD,
    OP_MFHI  = 4'hE,
    OP_MFLO  = 4'hF
  } alu_op_e;

  // Bit positions inside the 4-bit {RegWrite, MemRead, MemWrite, MemtoReg} bundle
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Select 11 falls back to the ID/EX value
  function automatic logic [31:0] fwd_pick(input logic [1:0] sel,
                                           input logic [31:0] idex,
                                           input logic [31:0] mem,
                                           input logic [31:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return idex;
    endcase
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mult_iter.sv
// Iterative 32x32 shift-add multiplier, one partial product per cycle.
// Signed mode multiplies magnitudes and negates the 64-bit result.
module mult_iter
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  logic [63:0] acc_reg;
  logic [63:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [4:0]  count_reg;
  logic        running_reg;
  logic        neg_reg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      count_reg   <= '0;
      running_reg <= 1'b0;
      neg_reg     <= 1'b0;
    end else if (abort) begin
      running_reg <= 1'b0;
    end else if (start) begin
      acc_reg     <= '0;
      mcand_reg   <= {32'd0, a_mag};
      mplier_reg  <= b_mag;
      count_reg   <= '0;
      running_reg <= 1'b1;
      neg_reg     <= is_signed & (a[31] ^ b[31]);
    end else if (running_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 5'd1;
      if (count_reg == 5'(MUL_ITERS - 1)) begin
        running_reg <= 1'b0;
      end
    end
  end

  // done marks the cycle performing the final iteration; product is complete after that edge
  assign done    = running_reg && (count_reg == 5'(MUL_ITERS - 1));
  assign product = neg_reg ? (~acc_reg + 64'd1) : acc_reg;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO with an iterative
// multiplier, and the EX/MEM pipeline register.
module exe_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Forward_MUX1,
  input  logic [1:0]        Forward_MUX2,
  input  logic [DATA_W-1:0] Rs_data_EXE,
  input  logic [DATA_W-1:0] Rt_data_EXE,
  input  logic [DATA_W-1:0] Imm_EXE,
  input  logic [4:0]        Rt_EXE,
  input  logic [4:0]        Rd_EXE,
  input  logic              ALUSrc_EXE,
  input  logic              RegDst_EXE,
  input  logic [3:0]        ALUOp_EXE,
  input  logic [3:0]        Ctrl_EXE,
  input  logic              Valid_EXE,
  input  logic              Flush_EXE,
  input  logic [DATA_W-1:0] WB_data,
  output logic [DATA_W-1:0] ALU_result_MEM,
  output logic [DATA_W-1:0] Store_data_MEM,
  output logic [4:0]        RegWr_MEM,
  output logic [3:0]        Ctrl_MEM,
  output logic              Valid_MEM,
  output logic              Busy
);

  logic [DATA_W-1:0] alu_result_reg;
  logic [DATA_W-1:0] store_data_reg;
  logic [4:0]        regwr_reg;
  logic [3:0]        ctrl_reg;
  logic              valid_reg;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  mul_state_e        state_reg;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        dest;
  logic [4:0]        shamt;
  logic [3:0]        ctrl_mul;
  logic              mul_start;
  logic              mul_done;
  logic [63:0]       mul_product;

  always_comb begin
    fwd_rs = fwd_pick(Forward_MUX1, Rs_data_EXE, alu_result_reg, WB_data);
    fwd_rt = fwd_pick(Forward_MUX2, Rt_data_EXE, alu_result_reg, WB_data);
    op_a   = fwd_rs;
    op_b   = ALUSrc_EXE ? Imm_EXE : fwd_rt;
    dest   = RegDst_EXE ? Rd_EXE : Rt_EXE;
    shamt  = Imm_EXE[10:6];
  end

  always_comb begin
    alu_res = '0;
    case (ALUOp_EXE)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
      OP_SLL:  alu_res = fwd_rt << shamt;
      OP_SRL:  alu_res = fwd_rt >> shamt;
      OP_SRA:  alu_res = DATA_W'($signed(fwd_rt) >>> shamt);
      OP_LUI:  alu_res = {Imm_EXE[15:0], 16'd0};
      OP_MFHI: alu_res = hi_reg;
      OP_MFLO: alu_res = lo_reg;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ctrl_mul                = Ctrl_EXE;
    ctrl_mul[CTRL_REGWRITE] = 1'b0;
  end

  assign mul_start = (state_reg == ST_IDLE) && Valid_EXE && is_mult_op(ALUOp_EXE) && !Flush_EXE;
  assign Busy      = !Reset && (mul_start || ((state_reg == ST_MUL) && !Flush_EXE));

  mult_iter u_mult (
    .clk       (Clk),
    .srst      (Reset),
    .start     (mul_start),
    .abort     (Flush_EXE),
    .is_signed (ALUOp_EXE == OP_MULT),
    .a         (op_a),
    .b         (op_b),
    .done      (mul_done),
    .product   (mul_product)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (mul_start) state_reg <= ST_MUL;
        ST_MUL: begin
          if (Flush_EXE)     state_reg <= ST_IDLE;
          else if (mul_done) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          if (!Flush_EXE) begin
            hi_reg <= mul_product[63:32];
            lo_reg <= mul_product[31:0];
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bubble whenever the slot is killed, stalled or empty; DONE retires the multiply itself
  always_ff @(posedge Clk) begin
    if (Reset || Flush_EXE || Busy) begin
      alu_result_reg <= '0;
      store_data_reg <= '0;
      regwr_reg      <= '0;
      ctrl_reg       <= '0;
      valid_reg      <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      alu_result_reg <= mul_product[31:0];
      store_data_reg <= fwd_rt;
      regwr_reg      <= dest;
      ctrl_reg       <= ctrl_mul;
      valid_reg      <= 1'b1;
    end else if (!Valid_EXE) begin
      alu_result_reg <= '0;
      store_data_reg <= '0;
      regwr_reg      <= '0;
      ctrl_reg       <= '0;
      valid_reg      <= 1'b0;
    end else begin
      alu_result_reg <= alu_res;
      store_data_reg <= fwd_rt;
      regwr_reg      <= dest;
      ctrl_reg       <= Ctrl_EXE;
      valid_reg      <= 1'b1;
    end
  end

  assign ALU_result_MEM = alu_result_reg;
  assign Store_data_MEM = store_data_reg;
  assign RegWr_MEM      = regwr_reg;
  assign Ctrl_MEM       = ctrl_reg;
  assign Valid_MEM      = valid_reg;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: table of single-cycle ALU vectors plus
// hand-written multiply, flush and reset sequences.
module tb_exe_stage;
  import pipeline_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Forward_MUX1, Forward_MUX2;
  logic [31:0] Rs_data_EXE, Rt_data_EXE, Imm_EXE, WB_data;
  logic [4:0]  Rt_EXE, Rd_EXE;
  logic        ALUSrc_EXE, RegDst_EXE;
  logic [3:0]  ALUOp_EXE, Ctrl_EXE;
  logic        Valid_EXE, Flush_EXE;
  logic [31:0] ALU_result_MEM, Store_data_MEM;
  logic [4:0]  RegWr_MEM;
  logic [3:0]  Ctrl_MEM;
  logic        Valid_MEM, Busy;

  int checks = 0;
  int errors = 0;

  exe_stage #(.DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .Forward_MUX1(Forward_MUX1), .Forward_MUX2(Forward_MUX2),
    .Rs_data_EXE(Rs_data_EXE), .Rt_data_EXE(Rt_data_EXE), .Imm_EXE(Imm_EXE),
    .Rt_EXE(Rt_EXE), .Rd_EXE(Rd_EXE), .ALUSrc_EXE(ALUSrc_EXE), .RegDst_EXE(RegDst_EXE),
    .ALUOp_EXE(ALUOp_EXE), .Ctrl_EXE(Ctrl_EXE), .Valid_EXE(Valid_EXE), .Flush_EXE(Flush_EXE),
    .WB_data(WB_data), .ALU_result_MEM(ALU_result_MEM), .Store_data_MEM(Store_data_MEM),
    .RegWr_MEM(RegWr_MEM), .Ctrl_MEM(Ctrl_MEM), .Valid_MEM(Valid_MEM), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [31:0] wb;
    logic        alusrc;
    logic        regdst;
    logic [3:0]  op;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [3:0]  ctrl;
    logic [31:0] exp_res;
    logic [31:0] exp_store;
    logic [4:0]  exp_dst;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [4:0] rd, input logic [3:0] ctrl);
    Forward_MUX1 = FWD_IDEX; Forward_MUX2 = FWD_IDEX;
    Rs_data_EXE = rs; Rt_data_EXE = rt; Imm_EXE = 32'd0; WB_data = 32'd0;
    Rt_EXE = 5'd0; Rd_EXE = rd; ALUSrc_EXE = 1'b0; RegDst_EXE = 1'b1;
    ALUOp_EXE = op; Ctrl_EXE = ctrl; Valid_EXE = 1'b1; Flush_EXE = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge Clk); set_instr(OP_MFHI, 32'd0, 32'd0, 5'd20, 4'b1000);
    @(posedge Clk); #1;
    chk({tag, "_mfhi"}, ALU_result_MEM, exp_hi);
    $display("txn %s MFHI -> %h", tag, ALU_result_MEM);
    @(negedge Clk); set_instr(OP_MFLO, 32'd0, 32'd0, 5'd21, 4'b1000);
    @(posedge Clk); #1;
    chk({tag, "_mflo"}, ALU_result_MEM, exp_lo);
    $display("txn %s MFLO -> %h", tag, ALU_result_MEM);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, Valid_MEM, 1'b0);
    chk({tag, "_ctrl"}, Ctrl_MEM, 4'd0);
    chk({tag, "_regwr"}, RegWr_MEM, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic bubble_ok, done_seen;

    //        f1 f2 rs            rt            imm           wb            src dst op        rt rd  ctrl     exp_res       exp_store     dst
    vecs[0]  = '{0, 0, 32'd5,        32'd7,        32'd0,        32'd0,        0, 1, OP_ADD,  2, 3,  4'b1000, 32'd12,       32'd7,        3};
    vecs[1]  = '{1, 0, 32'd0,        32'd2,        32'd0,        32'd0,        0, 1, OP_SUB,  2, 4,  4'b1000, 32'd10,       32'd2,        4};
    vecs[2]  = '{0, 2, 32'h12345678, 32'd0,        32'd0,        32'hFFFF0000, 0, 1, OP_AND,  2, 5,  4'b1000, 32'h12340000, 32'hFFFF0000, 5};
    vecs[3]  = '{0, 0, 32'hF0,       32'h0F,       32'd0,        32'd0,        0, 1, OP_OR,   2, 6,  4'b1000, 32'hFF,       32'h0F,       6};
    vecs[4]  = '{0, 0, 32'hFF,       32'h0F,       32'd0,        32'd0,        0, 1, OP_XOR,  2, 7,  4'b1000, 32'hF0,       32'h0F,       7};
    vecs[5]  = '{0, 0, 32'd0,        32'd0,        32'd0,        32'd0,        0, 1, OP_NOR,  2, 8,  4'b1000, 32'hFFFFFFFF, 32'd0,        8};
    vecs[6]  = '{0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 1, OP_SLT,  2, 9,  4'b1000, 32'd1,        32'd1,        9};
    vecs[7]  = '{0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 1, OP_SLTU, 2, 10, 4'b1000, 32'd0,        32'd1,        10};
    vecs[8]  = '{0, 0, 32'd0,        32'd1,        32'h100,      32'd0,        0, 1, OP_SLL,  2, 11, 4'b1000, 32'h10,       32'd1,        11};
    vecs[9]  = '{0, 0, 32'd0,        32'h80000000, 32'h7C0,      32'd0,        0, 1, OP_SRL,  2, 12, 4'b1000, 32'd1,        32'h80000000, 12};
    vecs[10] = '{0, 0, 32'd0,        32'h80000000, 32'h100,      32'd0,        0, 1, OP_SRA,  2, 13, 4'b1000, 32'hF8000000, 32'h80000000, 13};
    vecs[11] = '{0, 0, 32'd0,        32'h55,       32'h1234,     32'd0,        1, 1, OP_LUI,  2, 14, 4'b1000, 32'h12340000, 32'h55,       14};
    vecs[12] = '{0, 0, 32'd1,        32'd9,        32'hFFFFFFFF, 32'd0,        1, 0, OP_ADD,  9, 15, 4'b1100, 32'd0,        32'd9,        9};
    vecs[13] = '{3, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        0, 1, OP_ADD,  2, 16, 4'b1000, 32'd0,        32'd1,        16};
    vecs[14] = '{0, 0, 32'd0,        32'd1,        32'd0,        32'd0,        0, 1, OP_SUB,  2, 17, 4'b0010, 32'hFFFFFFFF, 32'd1,        17};
    vecs[15] = '{0, 0, 32'd0,        32'd0,        32'd0,        32'd0,        0, 1, OP_MFHI, 2, 18, 4'b1000, 32'd0,        32'd0,        18};

    Reset = 1'b1;
    set_instr(OP_ADD, 32'd0, 32'd0, 5'd0, 4'd0);
    Valid_EXE = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset = 1'b0; #1;
    chk("rst_result", ALU_result_MEM, 32'd0);
    chk("rst_store", Store_data_MEM, 32'd0);
    chk_bubble("rst");
    chk("rst_busy", Busy, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge Clk);
      Forward_MUX1 = vecs[i].f1; Forward_MUX2 = vecs[i].f2;
      Rs_data_EXE = vecs[i].rs; Rt_data_EXE = vecs[i].rt; Imm_EXE = vecs[i].imm;
      WB_data = vecs[i].wb; ALUSrc_EXE = vecs[i].alusrc; RegDst_EXE = vecs[i].regdst;
      ALUOp_EXE = vecs[i].op; Rt_EXE = vecs[i].rt_idx; Rd_EXE = vecs[i].rd_idx;
      Ctrl_EXE = vecs[i].ctrl; Valid_EXE = 1'b1; Flush_EXE = 1'b0;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_result", i), ALU_result_MEM, vecs[i].exp_res);
      chk($sformatf("vec%0d_store", i), Store_data_MEM, vecs[i].exp_store);
      chk($sformatf("vec%0d_regwr", i), RegWr_MEM, vecs[i].exp_dst);
      chk($sformatf("vec%0d_ctrl", i), Ctrl_MEM, vecs[i].ctrl);
      chk($sformatf("vec%0d_valid", i), Valid_MEM, 1'b1);
      $display("txn vec%0d op=%h result=%h store=%h regwr=%0d", i, vecs[i].op,
               ALU_result_MEM, Store_data_MEM, RegWr_MEM);
    end

    @(negedge Clk); set_instr(OP_ADD, 32'd1, 32'd1, 5'd3, 4'b1000); Valid_EXE = 1'b0;
    @(posedge Clk); #1; chk_bubble("invalid");
    $display("txn invalid ADD -> valid=%b", Valid_MEM);
    @(negedge Clk); set_instr(OP_ADD, 32'd1, 32'd1, 5'd3, 4'b1000); Flush_EXE = 1'b1;
    @(posedge Clk); #1; chk_bubble("flush");
    $display("txn flushed ADD -> valid=%b", Valid_MEM);

    // MULT -3 x 4
    @(negedge Clk); set_instr(OP_MULT, 32'hFFFFFFFD, 32'd4, 5'd5, 4'b1000);
    busy_cnt = 0; bubble_ok = 1'b1; done_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!Busy) begin
        done_seen = 1'b1;
        break;
      end
      busy_cnt++;
      @(posedge Clk); #1;
      if (Valid_MEM !== 1'b0 || Ctrl_MEM !== 4'd0 || RegWr_MEM !== 5'd0) bubble_ok = 1'b0;
      @(negedge Clk);
    end
    chk("mult_done_seen", done_seen, 1'b1);
    chk("mult_busy_cycles", busy_cnt, 33);
    chk("mult_bubbles", bubble_ok, 1'b1);
    @(posedge Clk); #1;
    chk("mult_retire_valid", Valid_MEM, 1'b1);
    chk("mult_retire_ctrl", Ctrl_MEM, 4'b0000);
    chk("mult_retire_regwr", RegWr_MEM, 5'd5);
    $display("txn MULT -3x4 busy=%0d cycles retire valid=%b ctrl=%b", busy_cnt, Valid_MEM, Ctrl_MEM);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF4);

    // MULTU killed partway through
    @(negedge Clk); set_instr(OP_MULTU, 32'hFFFFFFFF, 32'd2, 5'd7, 4'b1000);
    @(posedge Clk);
    repeat (9) @(posedge Clk);
    @(negedge Clk); Flush_EXE = 1'b1; #1;
    chk("multu_flush_busy", Busy, 1'b0);
    @(posedge Clk); #1;
    chk("multu_flush_valid", Valid_MEM, 1'b0);
    @(negedge Clk); Flush_EXE = 1'b0; Valid_EXE = 1'b0; #1;
    chk("multu_flush_idle", Busy, 1'b0);
    $display("txn MULTU flushed at MUL cycle 10 busy=%b", Busy);
    read_hilo("multu_flush", 32'hFFFFFFFF, 32'hFFFFFFF4);

    // Reset in the middle of a multiply
    @(negedge Clk); set_instr(OP_MULT, 32'd7, 32'd7, 5'd8, 4'b1000);
    @(posedge Clk);
    repeat (5) @(posedge Clk);
    @(negedge Clk); Reset = 1'b1; Valid_EXE = 1'b0;
    @(posedge Clk); #1;
    chk("midrst_result", ALU_result_MEM, 32'd0);
    chk("midrst_store", Store_data_MEM, 32'd0);
    chk_bubble("midrst");
    chk("midrst_busy", Busy, 1'b0);
    @(negedge Clk); Reset = 1'b0; #1;
    chk("midrst_idle", Busy, 1'b0);
    $display("txn reset during MULT busy=%b", Busy);
    read_hilo("midrst", 32'd0, 32'd0);

    @(negedge Clk); set_instr(OP_ADD, 32'd3, 32'd4, 5'd9, 4'b1000);
    @(posedge Clk); #1;
    chk("post_rst_add", ALU_result_MEM, 32'd7);
    chk("post_rst_valid", Valid_MEM, 1'b1);
    $display("txn ADD 3+4 after reset -> %h", ALU_result_MEM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
